// File: rtl/rshift_reg_n.sv
// Word-level bidirectional shift register for the CAN bit-stream path: parallel load,
// saturating shift counter, full level and done strobe. Define RSHIFT_CRC15_EN for CRC-15 accumulation.
module rshift_reg_n #(
    parameter int                   WIDTH     = 8,
    parameter int                   CNT_W     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             clear,
    input  logic             dir,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
`ifdef RSHIFT_CRC15_EN
    output logic             done,
    output logic [14:0]      crc
`else
    output logic             done
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_shifted;
    logic [CNT_W-1:0] count_sat;
    logic [CNT_W:0]   count_inc;

    assign serial_out = dir ? q[WIDTH-1] : q[0];
    assign q_shifted  = dir ? {q[WIDTH-2:0], serial_in} : {serial_in, q[WIDTH-1:1]};
    assign count_inc  = {1'b0, count} + (CNT_W+1)'(1);
    assign count_sat  = (count == CNT_MAX) ? count : count_inc[CNT_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q     <= RESET_VAL;
            count <= '0;
            full  <= 1'b0;
            done  <= 1'b0;
        end else if (clear) begin
            q     <= RESET_VAL;
            count <= '0;
            full  <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            q     <= par_in;
            count <= '0;
            full  <= 1'b0;
            done  <= 1'b0;
        end else if (enable) begin
            q     <= q_shifted;
            count <= count_sat;
            full  <= (count_inc >= (CNT_W+1)'(WIDTH));
            // Only the shift that reaches WIDTH strobes; saturated shifts stay quiet.
            done  <= (count == CNT_LAST);
        end else begin
            done  <= 1'b0;
        end
    end

`ifdef RSHIFT_CRC15_EN
    logic crc_nxt;

    assign crc_nxt = serial_in ^ crc[14];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear || load) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[13:0], 1'b0} ^ (crc_nxt ? 15'h4599 : 15'h0000);
        end
    end
`endif

endmodule
